fwdtransform_luma4x4: RTL

FWDTRANSFORM_LUMA4X4 -- requirements
Module: fwdtransform_luma4x4

---
 rtl/intrapred_pkg.sv | 33 +++
 rtl/fwdtransform_luma4x4_butterfly4.sv | 45 ++++
 rtl/fwdtransform_luma4x4.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/intrapred_pkg.sv
// Shared intra-coding package: default widths, forward-transform constants
// and the load/emit state encoding used by the 4x4 luma transform.
package intrapred_pkg;

   // Default residual and coefficient widths.
   localparam int IN_W_DEF  = 9;
   localparam int OUT_W_DEF = 16;

   // Width of the intermediate row-pass buffer; 9-bit residuals grow by at
   // most a factor of 6 through one butterfly, so 12 signed bits always fit.
   localparam int BUF_W = 12;

   // Forward core-transform matrix C (documentation only; the datapath uses
   // the equivalent shift/add butterfly).
   localparam int C_MAT [4][4] = '{
      '{ 1,  1,  1,  1},
      '{ 2,  1, -1, -2},
      '{ 1, -1, -1,  1},
      '{ 1, -2,  2, -1}
   };

   // Block-level state: collect four input rows, then emit four output rows.
   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_EMIT = 1'b1
   } fwd_state_t;

   // Modulo-4 row index advance.
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/fwdtransform_luma4x4_butterfly4.sv
// Combinational 4-point forward core-transform butterfly.
// LANES independent butterflies run side by side: lane k takes element k of
// each of the four input vectors, so a 4-lane instance applied to four buffer
// rows transforms all four columns at once.  OUT_W must exceed IN_W.
module butterfly4
   import intrapred_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = BUF_W,
   parameter int LANES = 1
) (
   input  logic [LANES*IN_W-1:0]  i_p0,
   input  logic [LANES*IN_W-1:0]  i_p1,
   input  logic [LANES*IN_W-1:0]  i_p2,
   input  logic [LANES*IN_W-1:0]  i_p3,
   output logic [LANES*OUT_W-1:0] o_q0,
   output logic [LANES*OUT_W-1:0] o_q1,
   output logic [LANES*OUT_W-1:0] o_q2,
   output logic [LANES*OUT_W-1:0] o_q3
);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [OUT_W-1:0] w_x0, w_x1, w_x2, w_x3;
      logic [OUT_W-1:0] w_s0, w_s1, w_d0, w_d1;

      // Sign-extend each lane input to the output width before any add.
      assign w_x0 = {{(OUT_W-IN_W){i_p0[k*IN_W+IN_W-1]}}, i_p0[k*IN_W +: IN_W]};
      assign w_x1 = {{(OUT_W-IN_W){i_p1[k*IN_W+IN_W-1]}}, i_p1[k*IN_W +: IN_W]};
      assign w_x2 = {{(OUT_W-IN_W){i_p2[k*IN_W+IN_W-1]}}, i_p2[k*IN_W +: IN_W]};
      assign w_x3 = {{(OUT_W-IN_W){i_p3[k*IN_W+IN_W-1]}}, i_p3[k*IN_W +: IN_W]};

      // First butterfly stage: sums and differences of mirrored pairs.
      assign w_s0 = w_x0 + w_x3;
      assign w_s1 = w_x1 + w_x2;
      assign w_d0 = w_x0 - w_x3;
      assign w_d1 = w_x1 - w_x2;

      // Second stage; the factor 2 is a left shift, two's complement safe.
      assign o_q0[k*OUT_W +: OUT_W] = w_s0 + w_s1;
      assign o_q1[k*OUT_W +: OUT_W] = {w_d0[OUT_W-2:0], 1'b0} + w_d1;
      assign o_q2[k*OUT_W +: OUT_W] = w_s0 - w_s1;
      assign o_q3[k*OUT_W +: OUT_W] = w_d0 - {w_d1[OUT_W-2:0], 1'b0};
   end

endmodule

// File: rtl/fwdtransform_luma4x4.sv
// 4x4 luma forward integer transform Y = C*X*C^T.
// Rows arrive one per input handshake and are row-transformed on the fly into
// a 12-bit buffer; after the fourth row the column pass is applied to the
// whole buffer and the four coefficient rows are emitted one per output
// handshake.  Row 0 is registered in the same edge as the fourth input row by
// feeding the live row-pass result into the column pass in place of buffer
// row 3.
module fwdtransform_luma4x4
   import intrapred_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4*IN_W-1:0]  in_row,
   input  logic [3:0]         in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4*OUT_W-1:0] out_row,
   output logic [3:0]         out_tag
);

   fwd_state_t r_state;
   fwd_state_t w_state_nxt;
   logic [1:0]         r_row_cnt;
   logic [1:0]         r_out_cnt;
   logic [3:0]         r_tag;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [4*OUT_W-1:0] r_out_row;
   logic [3:0]         r_out_tag;
   logic [4*BUF_W-1:0] r_buf [4];

   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_last_in;
   logic               w_last_out;
   logic [BUF_W-1:0]   w_z0, w_z1, w_z2, w_z3;
   logic [4*BUF_W-1:0] w_z_row;
   logic [4*BUF_W-1:0] w_col3;
   logic [4*OUT_W-1:0] w_y [4];

   // in_ready/out_valid are only ever high in LOAD/EMIT respectively, so the
   // handshakes need no extra state qualification.
   assign w_in_fire  = enable & in_valid  & r_in_ready;
   assign w_out_fire = enable & out_ready & r_out_valid;
   assign w_last_in  = (r_row_cnt == 2'd3);
   assign w_last_out = (r_out_cnt == 2'd3);

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_row   = r_out_row;
   assign out_tag   = r_out_tag;

   // Row pass on the incoming residual row.
   butterfly4 #(
      .IN_W  (IN_W),
      .OUT_W (BUF_W),
      .LANES (1)
   ) u_row_pass (
      .i_p0 (in_row[0*IN_W +: IN_W]),
      .i_p1 (in_row[1*IN_W +: IN_W]),
      .i_p2 (in_row[2*IN_W +: IN_W]),
      .i_p3 (in_row[3*IN_W +: IN_W]),
      .o_q0 (w_z0),
      .o_q1 (w_z1),
      .o_q2 (w_z2),
      .o_q3 (w_z3)
   );

   assign w_z_row = {w_z3, w_z2, w_z1, w_z0};

   // While loading, the fourth row is not yet in the buffer: use it live.
   always_comb begin
      w_col3 = r_buf[3];
      if (r_state == ST_LOAD) begin
         w_col3 = w_z_row;
      end else begin
         w_col3 = r_buf[3];
      end
   end

   // Column pass: four lanes, one per buffer column, yielding all 16 coefficients.
   butterfly4 #(
      .IN_W  (BUF_W),
      .OUT_W (OUT_W),
      .LANES (4)
   ) u_col_pass (
      .i_p0 (r_buf[0]),
      .i_p1 (r_buf[1]),
      .i_p2 (r_buf[2]),
      .i_p3 (w_col3),
      .o_q0 (w_y[0]),
      .o_q1 (w_y[1]),
      .o_q2 (w_y[2]),
      .o_q3 (w_y[3])
   );

   // Next-state logic for the LOAD -> EMIT -> LOAD cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOAD: begin
            if (w_in_fire && w_last_in) begin
               w_state_nxt = ST_EMIT;
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_EMIT: begin
            if (w_out_fire && w_last_out) begin
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = ST_EMIT;
            end
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // State, row/output counters and the block tag; frozen while enable is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_LOAD;
         r_row_cnt <= 2'd0;
         r_out_cnt <= 2'd0;
         r_tag     <= 4'd0;
      end else if (enable) begin
         r_state <= w_state_nxt;
         if (w_in_fire) begin
            r_row_cnt <= next_idx(r_row_cnt);
         end
         if (w_out_fire) begin
            r_out_cnt <= next_idx(r_out_cnt);
         end
         if (w_in_fire && (r_row_cnt == 2'd0)) begin
            r_tag <= in_tag;
         end
      end
   end

   // Registered handshake flags and output row/tag; held while enable is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_row   <= '0;
         r_out_tag   <= 4'd0;
      end else if (enable) begin
         r_in_ready  <= (w_state_nxt == ST_LOAD);
         r_out_valid <= (w_state_nxt == ST_EMIT);
         if (w_in_fire && w_last_in) begin
            r_out_row <= w_y[0];
            r_out_tag <= r_tag;
         end else if (w_out_fire && !w_last_out) begin
            r_out_row <= w_y[next_idx(r_out_cnt)];
         end
      end
   end

   // Row-pass buffer; a partial block is discarded by the counter reset, so
   // the contents themselves never need clearing.
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_buf[r_row_cnt] <= w_z_row;
      end
   end

endmodule
